// File: rtl/rgb_pixel_fifo.sv
// rtl/rgb_pixel_fifo.sv - buffers 1-or-2 pixel decoder beats and emits one 24-bit pixel per cycle
module rgb_pixel_fifo #(
    parameter int DEPTH       = 16,
    parameter int LEVEL_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [47:0]            rgb,
    input  logic [1:0]             rgb_enable,
    output logic [23:0]            pixel_data,
    output logic                   pixel_valid,
    input  logic                   pixel_ready,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   overflow,
    output logic                   protocol_error
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [23:0]            mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LEVEL_WIDTH-1:0] level_q;
    logic [LEVEL_WIDTH-1:0] free;
    logic [1:0]             n;
    logic                   accept;
    logic                   rd;

    // Space is judged on the start-of-cycle level only, so a same-cycle read never frees room.
    always_comb begin
        n = 2'd0;
        case (rgb_enable)
            2'b01:   n = 2'd1;
            2'b11:   n = 2'd2;
            default: n = 2'd0;
        endcase
        free   = LEVEL_WIDTH'(DEPTH) - level_q;
        accept = (n != 2'd0) && (free >= LEVEL_WIDTH'(n));
        rd     = pixel_ready && (level_q != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level_q        <= '0;
            overflow       <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PTR_W'(n);
            if (rd)
                rd_ptr <= rd_ptr + PTR_W'(1);
            level_q <= level_q + (accept ? LEVEL_WIDTH'(n) : '0) - (rd ? LEVEL_WIDTH'(1) : '0);
            if ((n != 2'd0) && !accept)
                overflow <= 1'b1;
            if (rgb_enable == 2'b10)
                protocol_error <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            mem[wr_ptr] <= rgb[23:0];
            if (n == 2'd2)
                mem[wr_ptr + PTR_W'(1)] <= rgb[47:24];
        end
    end

    assign level       = level_q;
    assign pixel_valid = (level_q != '0);
    assign pixel_data  = pixel_valid ? mem[rd_ptr] : 24'd0;
endmodule

// File: tb/tb_rgb_pixel_fifo.sv
// tb/tb_rgb_pixel_fifo.sv - directed and scoreboarded checks for rgb_pixel_fifo
module tb_rgb_pixel_fifo;
    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [47:0] rgb = '0;
    logic [1:0]  rgb_enable = '0;
    logic        pixel_ready = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [4:0]  level;
    logic        overflow;
    logic        protocol_error;

    int errors = 0;
    int checks = 0;
    logic [23:0] q[$];
    logic m_ovf = 1'b0;
    logic m_perr = 1'b0;

    rgb_pixel_fifo #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .rgb(rgb), .rgb_enable(rgb_enable),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .level(level), .overflow(overflow), .protocol_error(protocol_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] en, input logic [47:0] d, input logic rdy);
        int n;
        int lvl;
        rgb_enable  = en;
        rgb         = d;
        pixel_ready = rdy;
        lvl = q.size();
        n = (en == 2'b01) ? 1 : (en == 2'b11) ? 2 : 0;
        @(posedge clock);
        if (reset) begin
            q.delete();
            m_ovf  = 1'b0;
            m_perr = 1'b0;
        end else begin
            if (en == 2'b10) m_perr = 1'b1;
            if (rdy && lvl > 0) void'(q.pop_front());
            if (n > 0) begin
                if (DEPTH - lvl >= n) begin
                    q.push_back(d[23:0]);
                    if (n == 2) q.push_back(d[47:24]);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".level"}, 32'(level), 32'(q.size()));
        check({tag, ".valid"}, 32'(pixel_valid), 32'(q.size() != 0));
        check({tag, ".data"}, 32'(pixel_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".perr"}, 32'(protocol_error), 32'(m_perr));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(2'b11, 48'hDEAD_BEEF_CAFE, 1'b1);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst.level", 32'(level), 0);
        check("rst.valid", 32'(pixel_valid), 0);
        check("rst.data", 32'(pixel_data), 0);
        check("rst.ovf", 32'(overflow), 0);
        check("rst.perr", 32'(protocol_error), 0);

        // single pixel, first-word latency of one cycle
        drive(2'b01, 48'h0000_0011_2233, 1'b1);
        check("t1.valid", 32'(pixel_valid), 1);
        check("t1.data", 32'(pixel_data), 32'h112233);
        check("t1.level", 32'(level), 1);
        drive(2'b00, 48'h0, 1'b1);
        check("t1.valid2", 32'(pixel_valid), 0);
        check("t1.data2", 32'(pixel_data), 0);

        // two-pixel beat comes out pixel 0 first
        drive(2'b11, {24'hAABBCC, 24'h010203}, 1'b1);
        check("t2.data0", 32'(pixel_data), 32'h010203);
        check("t2.level0", 32'(level), 2);
        drive(2'b00, 48'h0, 1'b1);
        check("t2.data1", 32'(pixel_data), 32'hAABBCC);
        check("t2.level1", 32'(level), 1);
        drive(2'b00, 48'h0, 1'b1);
        check("t2.level2", 32'(level), 0);

        // fill to full, overflow on ninth beat, then drain in order
        for (int k = 0; k < 8; k++)
            drive(2'b11, {24'(32'h100 + 2 * k + 1), 24'(32'h100 + 2 * k)}, 1'b0);
        check("t3.full", 32'(level), 16);
        check("t3.ovf0", 32'(overflow), 0);
        drive(2'b01, 48'h0000_00FF_FFFF, 1'b0);
        check("t3.lvl", 32'(level), 16);
        check("t3.ovf1", 32'(overflow), 1);
        for (int i = 0; i < 16; i++) begin
            check("t3.dvalid", 32'(pixel_valid), 1);
            check("t3.drain", 32'(pixel_data), 32'h100 + 32'(i));
            drive(2'b00, 48'h0, 1'b1);
        end
        check("t3.empty", 32'(level), 0);

        // all-or-nothing drop at level 15, read+write at full and at DEPTH-2
        do_reset();
        for (int k = 0; k < 7; k++)
            drive(2'b11, {24'(32'h200 + 2 * k + 1), 24'(32'h200 + 2 * k)}, 1'b0);
        check("t4.l14", 32'(level), 14);
        drive(2'b11, {24'h00021F, 24'h00021E}, 1'b1);
        check("t4.rw14", 32'(level), 15);
        check("t4.ovf0", 32'(overflow), 0);
        drive(2'b11, {24'h000333, 24'h000222}, 1'b0);
        check("t4.drop", 32'(level), 15);
        check("t4.ovf1", 32'(overflow), 1);
        drive(2'b01, 48'h0000_0044_4444, 1'b0);
        check("t4.l16", 32'(level), 16);
        drive(2'b01, 48'h0000_0055_5555, 1'b1);
        check("t4.rwfull", 32'(level), 15);
        check("t4.ovfst", 32'(overflow), 1);
        check("t4.head", 32'(pixel_data), 32'h000202);

        // illegal enable code
        do_reset();
        drive(2'b10, 48'h0000_0012_3456, 1'b0);
        check("t5.perr", 32'(protocol_error), 1);
        check("t5.level", 32'(level), 0);
        drive(2'b01, 48'h0000_0065_4321, 1'b0);
        check("t5.lvl1", 32'(level), 1);
        check("t5.data", 32'(pixel_data), 32'h654321);

        // sustained 2-pixel beat every third cycle with continuous ready
        do_reset();
        for (int k = 0; k < 30; k++) begin
            if (k % 3 == 0) drive(2'b11, {24'(k + 1), 24'(k)}, 1'b1);
            else            drive(2'b00, 48'h0, 1'b1);
            check_model("tput");
        end
        check("tput.ovf", 32'(overflow), 0);

        // random scoreboard run with mid-stream reset
        do_reset();
        for (int k = 0; k < 100; k++) begin
            logic [1:0]  en;
            logic [47:0] d;
            if (k == 50) begin
                do_reset();
                check("rr.level", 32'(level), 0);
                check("rr.valid", 32'(pixel_valid), 0);
                check("rr.ovf", 32'(overflow), 0);
                check("rr.perr", 32'(protocol_error), 0);
            end
            en = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01;
            d  = {16'($urandom), 32'($urandom)};
            drive(en, d, 1'($urandom_range(0, 1)));
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
